// File: rtl/mem_arb_pkg.sv
// Shared types and constants for mem_port_arbiter and its grant chooser.
// The DATA_ADDR_MODE_* encodings normally come from def.sv; the fallbacks keep this slice standalone.
`ifndef DATA_ADDR_MODE_B
`define DATA_ADDR_MODE_B 3'b000
`endif
`ifndef DATA_ADDR_MODE_H
`define DATA_ADDR_MODE_H 3'b001
`endif
`ifndef DATA_ADDR_MODE_W
`define DATA_ADDR_MODE_W 3'b010
`endif

package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
  typedef enum logic {REQ_IF, REQ_DC} req_id_t;

  localparam int MODE_W = 3;
  localparam logic [MODE_W-1:0] MODE_BYTE    = `DATA_ADDR_MODE_B;
  localparam logic [MODE_W-1:0] MODE_HALF    = `DATA_ADDR_MODE_H;
  localparam logic [MODE_W-1:0] MODE_WORD    = `DATA_ADDR_MODE_W;
  // Instruction refills always move whole words.
  localparam logic [MODE_W-1:0] IF_ADDR_MODE = `DATA_ADDR_MODE_W;

endpackage

// File: rtl/arb_pick.sv
// Combinational 2-way chooser between the IF and DC requesters.
// Policy macro ARB_ROUND_ROBIN_EN: alternate on contention; otherwise DC always beats IF.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic    if_req,
  input  logic    dc_req,
  input  req_id_t last_grant,
  output req_id_t winner
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    winner = REQ_DC;
    if (if_req && dc_req) begin
      winner = (last_grant == REQ_IF) ? REQ_DC : REQ_IF;
    end else if (if_req) begin
      winner = REQ_IF;
    end
  end
`else
  // Fixed priority has no use for the grant history.
  logic unused_last;
  assign unused_last = (last_grant == REQ_DC);

  always_comb begin
    winner = REQ_DC;
    if (if_req && !dc_req) begin
      winner = REQ_IF;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the data_mem port between IF refills and DC accesses, one transaction at a time,
// with a WAIT-state watchdog. Grant policy macro: ARB_ROUND_ROBIN_EN (else fixed DC > IF).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dc_req,
  input  logic                  dc_we,
  input  logic [MODE_W-1:0]     dc_addr_mode,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic [DATA_WIDTH-1:0] dc_wdata,
  output logic                  dc_ack,
  output logic [DATA_WIDTH-1:0] dc_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MODE_W-1:0]     mem_addr_mode,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  arb_state_t            state_q, state_d;
  req_id_t               owner_q, owner_d;
  req_id_t               last_q, last_d;
  req_id_t               pick_win;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [MODE_W-1:0]     mode_q, mode_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dc_rdata_q, dc_rdata_d;
  logic                  terr_q, terr_d;
  logic [DATA_WIDTH-1:0] rdata_cap;

  arb_pick u_pick (
    .if_req     (if_req),
    .dc_req     (dc_req),
    .last_grant (last_q),
    .winner     (pick_win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= REQ_IF;
      last_q     <= REQ_IF;
      cnt_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      mode_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dc_rdata_q <= '0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      mode_q     <= mode_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dc_rdata_q <= dc_rdata_d;
      terr_q     <= terr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    mode_d     = mode_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dc_rdata_d = dc_rdata_q;
    terr_d     = terr_q;
    rdata_cap  = '0;
    mem_req    = 1'b0;
    if_ack     = 1'b0;
    dc_ack     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (if_req || dc_req) begin
          owner_d = pick_win;
          last_d  = pick_win;
          if (pick_win == REQ_DC) begin
            addr_d  = dc_addr;
            we_d    = dc_we;
            mode_d  = dc_addr_mode;
            wdata_d = dc_wdata;
          end else begin
            addr_d  = if_addr;
            we_d    = 1'b0;
            mode_d  = IF_ADDR_MODE;
            wdata_d = '0;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_req = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        mem_req = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        // A late mem_ready on the final watchdog cycle still completes normally.
        if (mem_ready || (cnt_q == CNT_MAX)) begin
          rdata_cap = mem_ready ? mem_rdata : '0;
          if (!mem_ready) begin
            terr_d = 1'b1;
          end
          if (owner_q == REQ_IF) begin
            if_rdata_d = rdata_cap;
          end else if (!we_q) begin
            dc_rdata_d = rdata_cap;
          end
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if_ack  = (owner_q == REQ_IF);
        dc_ack  = (owner_q == REQ_DC);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs are forced low outside the active window.
  assign mem_we        = mem_req & we_q;
  assign mem_addr_mode = mem_req ? mode_q  : '0;
  assign mem_addr      = mem_req ? addr_q  : '0;
  assign mem_wdata     = mem_req ? wdata_q : '0;
  assign if_rdata      = if_rdata_q;
  assign dc_rdata      = dc_rdata_q;
  assign timeout_err   = terr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          dc_req = 1'b0;
  logic          dc_we = 1'b0;
  logic [2:0]    dc_addr_mode = '0;
  logic [AW-1:0] dc_addr = '0;
  logic [DW-1:0] dc_wdata = '0;
  logic          dc_ack;
  logic [DW-1:0] dc_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [2:0]    mem_addr_mode;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          timeout_err;

  int n_checks = 0;
  int n_err = 0;

  // Reference state: who was granted last, and what each rdata register should hold.
  req_id_t       exp_last = REQ_IF;
  logic [DW-1:0] exp_if_rd = '0;
  logic [DW-1:0] exp_dc_rd = '0;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr_mode(dc_addr_mode), .dc_addr(dc_addr),
    .dc_wdata(dc_wdata), .dc_ack(dc_ack), .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_mode(mem_addr_mode), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".mem_req"}, 32'(mem_req), 0);
    chk({tag, ".mem_we"}, 32'(mem_we), 0);
    chk({tag, ".mem_mode"}, 32'(mem_addr_mode), 0);
    chk({tag, ".mem_addr"}, mem_addr, 0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0);
    chk({tag, ".if_ack"}, 32'(if_ack), 0);
    chk({tag, ".dc_ack"}, 32'(dc_ack), 0);
    chk({tag, ".if_rdata"}, if_rdata, 0);
    chk({tag, ".dc_rdata"}, dc_rdata, 0);
    chk({tag, ".timeout_err"}, 32'(timeout_err), 0);
  endtask

  // Grant rule: a lone requester wins; on contention RR alternates, fixed mode picks DC.
  function automatic req_id_t predict(input logic ir, input logic dr);
    if (ir && !dr) return REQ_IF;
    if (dr && !ir) return REQ_DC;
`ifdef ARB_ROUND_ROBIN_EN
    return (exp_last == REQ_DC) ? REQ_IF : REQ_DC;
`else
    return REQ_DC;
`endif
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    if_req = 1'b0;
    dc_req = 1'b0;
    mem_ready = 1'b0;
    #1;
    exp_last  = REQ_IF;
    exp_if_rd = '0;
    exp_dc_rd = '0;
    check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge while the DUT is IDLE with requests set up; returns at the IDLE after DONE.
  task automatic run_one(input string tag, input int delay, input bit drop,
                         input logic [DW-1:0] rd, output req_id_t got);
    req_id_t       w;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    logic [2:0]    em;
    logic          ewe;
    w = predict(if_req, dc_req);
    exp_last = w;
    if (w == REQ_DC) begin
      ea = dc_addr; ewe = dc_we; em = dc_addr_mode; ew = dc_wdata;
    end else begin
      ea = if_addr; ewe = 1'b0; em = MODE_WORD; ew = '0;
    end
    @(negedge clk);
    chk({tag, ".issue_req"}, 32'(mem_req), 1);
    chk({tag, ".issue_addr"}, mem_addr, ea);
    chk({tag, ".issue_we"}, 32'(mem_we), 32'(ewe));
    chk({tag, ".issue_mode"}, 32'(mem_addr_mode), 32'(em));
    if (ewe) chk({tag, ".issue_wdata"}, mem_wdata, ew);
    chk({tag, ".issue_acks"}, {30'd0, if_ack, dc_ack}, 0);
    // The request register is latched, so later payload churn must not reach memory.
    if (w == REQ_DC) begin
      dc_addr = $urandom; dc_wdata = $urandom; dc_addr_mode = 3'($urandom); dc_we = 1'($urandom);
    end else begin
      if_addr = $urandom;
    end
    for (int k = 1; k <= delay; k++) begin
      @(negedge clk);
      chk({tag, ".wait_req"}, 32'(mem_req), 1);
      chk({tag, ".wait_addr"}, mem_addr, ea);
      chk({tag, ".wait_acks"}, {30'd0, if_ack, dc_ack}, 0);
      if (k == delay) begin
        mem_ready = 1'b1;
        mem_rdata = rd;
      end
    end
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    if (w == REQ_IF) exp_if_rd = rd;
    else if (!ewe) exp_dc_rd = rd;
    chk({tag, ".done_if_ack"}, 32'(if_ack), 32'(w == REQ_IF));
    chk({tag, ".done_dc_ack"}, 32'(dc_ack), 32'(w == REQ_DC));
    chk({tag, ".done_mem_req"}, 32'(mem_req), 0);
    chk({tag, ".if_rdata"}, if_rdata, exp_if_rd);
    chk({tag, ".dc_rdata"}, dc_rdata, exp_dc_rd);
    got = dc_ack ? REQ_DC : REQ_IF;
    if (drop) begin
      if (w == REQ_IF) if_req = 1'b0;
      else dc_req = 1'b0;
    end
    @(negedge clk);
    chk({tag, ".idle_acks"}, {30'd0, if_ack, dc_ack}, 0);
    chk({tag, ".idle_req"}, 32'(mem_req), 0);
  endtask

  initial begin
    req_id_t g;
    req_id_t ord [4];
    int      cnt;

    mem_rdata = $urandom;
    do_reset();

    // Async reset five cycles into WAIT of a DC read.
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h40; dc_addr_mode = MODE_WORD;
    @(negedge clk);
    chk("rstwait.issue", 32'(mem_req), 1);
    repeat (5) @(negedge clk);
    chk("rstwait.in_wait", 32'(mem_req), 1);
    rst_n = 1'b0;
    dc_req = 1'b0;
    #1;
    check_zero("rstwait");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_last = REQ_IF;
    repeat (3) begin
      @(negedge clk);
      chk("rstwait.no_ack", 32'(dc_ack), 0);
      chk("rstwait.idle", 32'(mem_req), 0);
    end

    // DC read, mem_ready three cycles after mem_req.
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h10; dc_addr_mode = MODE_WORD;
    run_one("dcread", 3, 1'b1, 32'hDEAD_BEEF, g);
    chk("dcread.rdata", dc_rdata, 32'hDEAD_BEEF);
    chk("dcread.if_rdata", if_rdata, 0);

    // DC byte write leaves dc_rdata alone.
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h13; dc_wdata = 32'hAB; dc_addr_mode = MODE_BYTE;
    run_one("dcwrite", 2, 1'b1, 32'h1111_2222, g);
    chk("dcwrite.rdata_kept", dc_rdata, 32'hDEAD_BEEF);

    // mem_ready while idle is ignored.
    mem_ready = 1'b1;
    mem_rdata = 32'h1234_5678;
    repeat (3) begin
      @(negedge clk);
      chk("idlerdy.acks", {30'd0, if_ack, dc_ack}, 0);
      chk("idlerdy.mem_req", 32'(mem_req), 0);
      chk("idlerdy.if_rdata", if_rdata, exp_if_rd);
    end
    mem_ready = 1'b0;

    // IF request held across its ack yields a fresh transaction, minimum latency on the second.
    if_req = 1'b1; if_addr = 32'h80;
    run_one("held1", 2, 1'b0, 32'hCAFE_0001, g);
    run_one("held2", 1, 1'b1, 32'hCAFE_0002, g);
    chk("held2.if_rdata", if_rdata, 32'hCAFE_0002);

    // Both requesters held for four transactions.
    do_reset();
`ifdef ARB_ROUND_ROBIN_EN
    ord[0] = REQ_DC; ord[1] = REQ_IF; ord[2] = REQ_DC; ord[3] = REQ_IF;
`else
    ord[0] = REQ_DC; ord[1] = REQ_DC; ord[2] = REQ_DC; ord[3] = REQ_DC;
`endif
    if_req = 1'b1; if_addr = 32'h100;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h200; dc_addr_mode = MODE_WORD;
    for (int i = 0; i < 4; i++) begin
      run_one("arb", 2, 1'b0, $urandom, g);
      chk("arb.order", 32'(g), 32'(ord[i]));
    end
    if_req = 1'b0;
    dc_req = 1'b0;
    @(negedge clk);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 40; t++) begin
      if (!if_req && ($urandom_range(0, 1) == 1)) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      if (!dc_req && ($urandom_range(0, 1) == 1)) begin
        dc_req = 1'b1; dc_we = 1'($urandom); dc_addr = $urandom; dc_wdata = $urandom;
        dc_addr_mode = ($urandom_range(0, 2) == 0) ? MODE_BYTE :
                       ($urandom_range(0, 1) == 0) ? MODE_HALF : MODE_WORD;
      end
      if (!if_req && !dc_req) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      run_one("rnd", int'($urandom_range(1, 6)), 1'b1, $urandom, g);
    end
    if_req = 1'b0;
    dc_req = 1'b0;
    @(negedge clk);

    // Watchdog: a DC read that memory never answers.
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h44; dc_addr_mode = MODE_WORD;
    run_one("pre_to", 1, 1'b1, 32'h5555_AAAA, g);
    chk("pre_to.rdata", dc_rdata, 32'h5555_AAAA);
    dc_req = 1'b1; dc_addr = 32'h48;
    @(negedge clk);
    chk("to.issue", 32'(mem_req), 1);
    cnt = 0;
    while (cnt < 31) begin
      @(negedge clk);
      cnt++;
      if (dc_ack) break;
    end
    chk("to.latency", 32'(cnt), 10);
    chk("to.rdata", dc_rdata, 0);
    chk("to.err", 32'(timeout_err), 1);
    dc_req = 1'b0;
    exp_dc_rd = '0;
    exp_last = REQ_DC;
    repeat (3) @(negedge clk);
    chk("to.err_sticky", 32'(timeout_err), 1);
    if_req = 1'b1; if_addr = 32'h300;
    run_one("post_to", 2, 1'b1, 32'h7777_0000, g);
    chk("post_to.err_sticky", 32'(timeout_err), 1);

    do_reset();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
